// File: rtl/ccff_pkg.sv
// ccff_pkg: state type and default chain/word sizes shared by the ccff loader files
package ccff_pkg;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_VERIFY, S_DONE} state_t;
  localparam int CHAIN_LEN_DEF = 22;
  localparam int WORD_W_DEF = 8;
endpackage

// File: rtl/ccff_word_shifter.sv
// ccff_word_shifter: one-word MSB-first buffer with a bits-remaining count
module ccff_word_shifter #(
  parameter int W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_load,
  input  logic [W-1:0]           i_data,
  input  logic [$clog2(W+1)-1:0] i_nbits,
  input  logic                   i_shift,
  output logic                   o_empty,
  output logic                   o_msb
);
  logic [W-1:0] r_buf;
  logic [$clog2(W+1)-1:0] r_cnt;
  assign o_empty = r_cnt == '0;
  assign o_msb = r_buf[W-1];
  always_ff @(posedge clk)
    if (rst) begin
      r_buf <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_buf <= i_data;
      r_cnt <= i_nbits;
    end else if (i_shift) begin
      r_buf <= r_buf << 1;
      r_cnt <= r_cnt - 1'b1;
    end
endmodule

// File: rtl/ccff_loader.sv
// ccff_loader: streams bitstream words serially into a ccff chain under a gated chain clock.
// Define CCFF_LOADER_VERIFY_EN to add the recirculating parity-verify pass.
module ccff_loader
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              prog_clk_en,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int NW = $clog2(WORD_W + 1);
  localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);
  state_t r_state;
  logic [CW-1:0] r_cnt, r_acc, w_rem;
  logic [NW-1:0] w_take;
  logic w_empty, w_msb, w_hs, w_shift, w_ver;
  // the last word only contributes the bits the chain still needs
  assign w_rem = CW'(CHAIN_LEN) - r_acc;
  assign w_take = (int'(w_rem) < WORD_W) ? NW'(w_rem) : NW'(WORD_W);
  assign w_ver = r_state == S_VERIFY;
  assign w_shift = r_state == S_LOAD && !w_empty;
  assign cfg_ready = r_state == S_LOAD && w_empty && r_acc != CW'(CHAIN_LEN);
  assign w_hs = cfg_ready && cfg_valid;
  assign prog_clk_en = w_shift || w_ver;
  assign ccff_head = w_shift ? w_msb : w_ver && ccff_tail;
  assign busy = r_state == S_LOAD || w_ver;
  assign done = r_state == S_DONE;
  ccff_word_shifter #(.W(WORD_W)) u_buf (
    .clk(prog_clk),
    .rst(prog_reset),
    .i_load(w_hs),
    .i_data(cfg_data),
    .i_nbits(w_take),
    .i_shift(w_shift),
    .o_empty(w_empty),
    .o_msb(w_msb)
  );
  always_ff @(posedge prog_clk)
    if (prog_reset) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_acc <= '0;
    end else
      case (r_state)
        S_IDLE:
          if (start) begin
            r_state <= S_LOAD;
            r_cnt <= '0;
            r_acc <= '0;
          end
        S_LOAD: begin
          if (w_hs) r_acc <= r_acc + CW'(w_take);
          if (w_shift) begin
            r_cnt <= r_cnt == LAST ? '0 : r_cnt + 1'b1;
`ifdef CCFF_LOADER_VERIFY_EN
            if (r_cnt == LAST) r_state <= S_VERIFY;
`else
            if (r_cnt == LAST) r_state <= S_DONE;
`endif
          end
        end
        S_VERIFY: begin
          r_cnt <= r_cnt == LAST ? '0 : r_cnt + 1'b1;
          if (r_cnt == LAST) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
`ifdef CCFF_LOADER_VERIFY_EN
  logic r_pl, r_pt, r_err;
  always_ff @(posedge prog_clk)
    if (prog_reset || (r_state == S_IDLE && start)) begin
      r_pl <= 1'b0;
      r_pt <= 1'b0;
      r_err <= 1'b0;
    end else if (w_shift)
      r_pl <= r_pl ^ w_msb;
    else if (w_ver) begin
      r_pt <= r_pt ^ ccff_tail;
      if (r_cnt == LAST) r_err <= r_pl != (r_pt ^ ccff_tail);
    end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_ccff_loader.sv
// tb_ccff_loader: scoreboard bench for ccff_loader with a 22-bit chain model on the serial ports
module tb_ccff_loader;
  localparam int N = 22;
`ifdef CCFF_LOADER_VERIFY_EN
  localparam int VER = N;
  localparam int LAT = N + 1;
`else
  localparam int VER = 0;
  localparam int LAT = 1;
`endif
  logic prog_clk = 1'b0, prog_reset = 1'b1, start = 1'b0, cfg_valid = 1'b0;
  logic [7:0] cfg_data = '0;
  logic cfg_ready, ccff_head, ccff_tail, prog_clk_en, busy, done, err;
  logic [N-1:0] chain = '0, exp_chain;
  logic flip = 1'b0;
  bit q[$];
  int n_chk = 0, n_pass = 0;
  int load_bits, ver_cnt, hs_cnt, done_cnt, low_en, cyc = 0, t22, tdone, pushed;
  ccff_loader #(.CHAIN_LEN(N), .WORD_W(8)) dut (
    .prog_clk(prog_clk),
    .prog_reset(prog_reset),
    .start(start),
    .cfg_data(cfg_data),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .ccff_head(ccff_head),
    .ccff_tail(ccff_tail),
    .prog_clk_en(prog_clk_en),
    .busy(busy),
    .done(done),
    .err(err)
  );
  always #5 prog_clk = ~prog_clk;
  assign ccff_tail = chain[N-1] ^ flip;
  always @(posedge prog_clk) if (prog_clk_en === 1'b1) chain <= {chain[N-2:0], ccff_head};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  always @(negedge prog_clk) begin
    cyc++;
    if (cfg_valid && cfg_ready) hs_cnt++;
    if (done) begin
      done_cnt++;
      tdone = cyc;
    end
    if (busy && load_bits < N) begin
      if (prog_clk_en) begin
        check("head_avail", 32'(q.size() > 0), 1);
        if (q.size() > 0) check($sformatf("head%0d", load_bits), ccff_head, q.pop_front());
        load_bits++;
        if (load_bits == N) t22 = cyc;
      end else low_en++;
    end else if (busy && prog_clk_en) ver_cnt++;
  end
  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask
  task automatic send_word(input logic [7:0] w, input int pre_gap, output bit acc);
    int t = 0;
    acc = 0;
    if (pre_gap > 0) begin
      while (!cfg_ready && t < 100) begin tick(); t++; end
      repeat (pre_gap) tick();
    end
    cfg_data = w;
    cfg_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      if (cfg_ready) begin
        acc = 1;
        for (int b = 7; b >= 0 && pushed < N; b--) begin q.push_back(w[b]); pushed++; end
        tick();
        break;
      end
      tick();
    end
    cfg_valid = 1'b0;
  endtask
  task automatic begin_load(input logic [7:0] w0, w1, w2);
    q.delete();
    {load_bits, ver_cnt, hs_cnt, done_cnt, low_en, t22, tdone, pushed} = '0;
    exp_chain = N'({w0, w1, w2} >> 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("err_cleared", err, 0);
  endtask
  task automatic do_load(input logic [7:0] w0, w1, w2, input int gap, input bit extra, input bit flip_it);
    bit a;
    begin_load(w0, w1, w2);
    send_word(w0, 0, a);
    check("acc_w0", a, 1);
    if (extra) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_in_load", busy, 1);
    end
    send_word(w1, gap, a);
    check("acc_w1", a, 1);
    send_word(w2, 0, a);
    check("acc_w2", a, 1);
    if (extra) begin
      send_word(8'h5A, 0, a);
      check("word4_rejected", a, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_in_done", busy, 0);
    end
    if (flip_it) begin
      for (int i = 0; i < 100 && ver_cnt < 3; i++) tick();
      flip = 1'b1;
      tick();
      flip = 1'b0;
    end
    for (int i = 0; i < 200 && done_cnt == 0; i++) tick();
    repeat (3) tick();
  endtask
  task automatic check_load(input string tag, input int exp_low);
    check({tag, "_hs"}, hs_cnt, 3);
    check({tag, "_done"}, done_cnt, 1);
    check({tag, "_bits"}, load_bits, N);
    check({tag, "_chain"}, chain, exp_chain);
    if (exp_low >= 0) check({tag, "_low_en"}, low_en, exp_low);
    check({tag, "_ver"}, ver_cnt, VER);
    check({tag, "_lat"}, tdone - t22, LAT);
    check({tag, "_err"}, err, 0);
    check({tag, "_busy"}, busy, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ready", cfg_ready, 0);
    check("rst_en", prog_clk_en, 0);
    check("rst_head", ccff_head, 0);
    prog_reset = 1'b0;
    tick();
    do_load(8'hA5, 8'h3C, 8'hFF, 0, 0, 0);
    check_load("basic", 3);
    do_load(8'hA5, 8'h3C, 8'hFF, 5, 0, 0);
    check_load("starve", 8);
    do_load(8'h01, 8'h80, 8'h55, 0, 0, 0);
    check_load("alt", 3);
`ifdef CCFF_LOADER_VERIFY_EN
    do_load(8'hA5, 8'h3C, 8'hFF, 0, 0, 1);
    check("flip_err", err, 1);
    repeat (5) tick();
    check("flip_err_sticky", err, 1);
    do_load(8'hA5, 8'h3C, 8'hFF, 0, 0, 0);
    check_load("after_flip", 3);
`endif
    begin
      bit a;
      begin_load(8'h12, 8'h34, 8'h56);
      send_word(8'h12, 0, a);
      send_word(8'h34, 0, a);
      for (int i = 0; i < 100 && load_bits < 10; i++) tick();
      prog_reset = 1'b1;
      tick();
      prog_reset = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_ready", cfg_ready, 0);
      check("abort_en", prog_clk_en, 0);
      check("abort_done", done, 0);
    end
    do_load(8'hA5, 8'h3C, 8'hFF, 0, 0, 0);
    check_load("reload", 3);
    do_load(8'hC3, 8'h0F, 8'hF0, 0, 1, 0);
    check_load("ignore", -1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 22: number of configuration flip-flops in the downstream ccff chain (min 1).
REQ-002 SHALL have parameter WORD_W, default 8: bitstream word width (min 1).
REQ-003 prog_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 prog_reset  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a load; honoured only in IDLE.
REQ-006 cfg_data  input  WORD_W  bitstream word; bit WORD_W-1 is shifted first.
REQ-007 cfg_valid  input  1  cfg_data valid.
REQ-008 cfg_ready  output  1  loader accepts cfg_data this cycle.
REQ-009 ccff_head  output  1  serial bit into the chain head.
REQ-010 ccff_tail  input  1  serial bit from the chain tail.
REQ-011 prog_clk_en  output  1  chain clock-gate enable; the chain advances only on cycles where it is 1.
REQ-012 busy  output  1  high in LOAD and VERIFY.
REQ-013 done  output  1  one-cycle pulse at end of operation.
REQ-014 err  output  1  verify mismatch flag, sticky until next accepted start.

Function
REQ-015 States: IDLE, LOAD, VERIFY, DONE; start in IDLE -> LOAD, clears bit counter, parity registers and err.
REQ-016 start outside IDLE SHALL be ignored.
REQ-017 Word buffer: one WORD_W shift register plus bits-remaining count; cfg_ready = LOAD and buffer empty and fewer than CHAIN_LEN bits accepted; handshake completes when cfg_valid and cfg_ready both high.
REQ-018 Accepted word SHALL be shifted MSB first, starting the cycle after acceptance; final word contributes only its top (CHAIN_LEN - accepted bits) bits, remaining bits discarded.
REQ-019 LOAD shift cycle (buffer non-empty): prog_clk_en=1, ccff_head = buffer MSB, bit counter +1, load parity ^= ccff_head.
REQ-020 LOAD starved (buffer empty): prog_clk_en=0, ccff_head=0, counter held; no chain bit lost or duplicated.
REQ-021 Counter reaching CHAIN_LEN SHALL exit LOAD next cycle (to VERIFY if enabled, else DONE); no further words accepted.
REQ-022 VERIFY: exactly CHAIN_LEN cycles with prog_clk_en=1, ccff_head=ccff_tail (recirculate, contents preserved), tail parity ^= ccff_tail.
REQ-023 End of VERIFY: err = (tail parity != load parity).
REQ-024 DONE: done=1 for one cycle, prog_clk_en=0, then IDLE.
REQ-025 Counter width SHALL be $clog2(CHAIN_LEN+1); no wrap.

Reset
REQ-026 prog_reset SHALL force IDLE, cfg_ready=0, prog_clk_en=0, ccff_head=0, busy=0, done=0, err=0, counters and buffer cleared; takes priority over start.
REQ-027 Reset mid-LOAD/VERIFY SHALL abort; chain contents then undefined; next start restarts from bit 0.

Configuration
REQ-028 Macro CCFF_LOADER_VERIFY_EN: defined -> VERIFY state and parity logic present; undefined -> LOAD goes directly to DONE, err tied 0, no parity registers.

Structure
REQ-029 Shared package ccff_pkg SHALL hold the state enum type and the default CHAIN_LEN/WORD_W constants.
REQ-030 Word buffer SHALL be sub-module ccff_word_shifter (load, shift, empty, msb).

Verification
REQ-031 Basic load, CHAIN_LEN=22, WORD_W=8, words 0xA5,0x3C,0xFF back-to-back -> ccff_head sequence 10100101 00111100 111111 on prog_clk_en cycles, exactly 3 handshakes, done pulse once.
REQ-032 Starvation: cfg_valid low 5 cycles after word 1 -> prog_clk_en low exactly 5 cycles, final chain model content identical to REQ-031.
REQ-033 Verify (macro on), chain modelled as 22-bit shift register -> 22 recirculate cycles, contents unchanged, err=0; one tail bit forced inverted -> err=1, held until next start.
REQ-034 Reset at bit 10 of LOAD -> next cycle busy=0, cfg_ready=0, prog_clk_en=0; new start reloads all 22 bits.
REQ-035 start pulsed during LOAD and DONE -> ignored, no extra handshake; 4th offered word never accepted.
REQ-036 Macro off -> done exactly 1 cycle after 22nd shift, err=0, no VERIFY cycles.
